// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the MIPS32 ALU control sequencer.
package mips_ctrl_pkg;

  localparam int ALU_CODE_W = 5;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  // ALU control codes (AND doubles as the beq equality comparator)
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 5'b00000;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 5'b00001;
  localparam logic [ALU_CODE_W-1:0] ALU_AND = 5'b00010;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 5'b00011;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR = 5'b00100;
  localparam logic [ALU_CODE_W-1:0] ALU_NOR = 5'b00101;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 5'b00110;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL = 5'b01000;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL = 5'b01001;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA = 5'b01010;
  localparam logic [ALU_CODE_W-1:0] ALU_BNE = 5'b01011;
  localparam logic [ALU_CODE_W-1:0] ALU_LUI = 5'b01100;

  // PC source select
  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, ALU_WAIT, MEM, WB, TRAP
  } state_t;

  typedef struct packed {
    logic rtype;
    logic itype;
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic illegal;
  } instr_class_t;

endpackage

// File: rtl/alu_ctrl_fsm_alu_op_decoder.sv
// Combinational opcode/funct decode into ALU code, operand selects and class.
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  output logic [ALU_CODE_W-1:0] alu_code,
  output logic                  imm_sext,
  output logic                  a_sel,
  output logic                  b_sel,
  output instr_class_t          cls
);

  // Decode table; anything not listed is flagged illegal
  always_comb begin
    alu_code = ALU_ADD;
    imm_sext = 1'b0;
    a_sel    = 1'b0;
    b_sel    = 1'b0;
    cls      = '0;
    case (opcode)
      OP_RTYPE: begin
        cls.rtype = 1'b1;
        case (funct)
          F_ADD, F_ADDU: alu_code = ALU_ADD;
          F_SUB, F_SUBU: alu_code = ALU_SUB;
          F_AND:         alu_code = ALU_AND;
          F_OR:          alu_code = ALU_OR;
          F_XOR:         alu_code = ALU_XOR;
          F_NOR:         alu_code = ALU_NOR;
          F_SLT:         alu_code = ALU_SLT;
          F_SLL: begin alu_code = ALU_SLL; a_sel = 1'b1; end
          F_SRL: begin alu_code = ALU_SRL; a_sel = 1'b1; end
          F_SRA: begin alu_code = ALU_SRA; a_sel = 1'b1; end
          default:       cls.illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        cls.itype = 1'b1; alu_code = ALU_ADD; imm_sext = 1'b1; b_sel = 1'b1;
      end
      OP_SLTI: begin
        cls.itype = 1'b1; alu_code = ALU_SLT; imm_sext = 1'b1; b_sel = 1'b1;
      end
      OP_ANDI: begin cls.itype = 1'b1; alu_code = ALU_AND; b_sel = 1'b1; end
      OP_ORI:  begin cls.itype = 1'b1; alu_code = ALU_OR;  b_sel = 1'b1; end
      OP_XORI: begin cls.itype = 1'b1; alu_code = ALU_XOR; b_sel = 1'b1; end
      OP_LUI:  begin cls.itype = 1'b1; alu_code = ALU_LUI; b_sel = 1'b1; end
      OP_LW: begin
        cls.load = 1'b1; alu_code = ALU_ADD; imm_sext = 1'b1; b_sel = 1'b1;
      end
      OP_SW: begin
        cls.store = 1'b1; alu_code = ALU_ADD; imm_sext = 1'b1; b_sel = 1'b1;
      end
      OP_BEQ:  begin cls.branch = 1'b1; alu_code = ALU_AND; end
      OP_BNE:  begin cls.branch = 1'b1; alu_code = ALU_BNE; end
      OP_J:    cls.jump = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle MIPS32 control sequencer driving the ALU and PC/memory strobes.
module alu_ctrl_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic                  alu_pcsinal,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  alu_a_sel,
  output logic                  alu_b_sel,
  output logic                  imm_sext,
  output logic                  reg_write,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  illegal
);

  state_t state, state_nxt;

  logic [ALU_CODE_W-1:0] dec_alu;
  logic                  dec_sext, dec_a_sel, dec_b_sel;
  instr_class_t          dec_cls;
  logic                  accept;

  logic [ALU_CTRL_W-1:0] alu_q;
  logic                  a_sel_q, b_sel_q, sext_q, reg_dst_q, dst_zero_q;
  logic                  load_q, store_q, branch_q, jump_q, illegal_q;

  logic unused_bits;
  assign unused_bits = ^{instr[25:21], instr[10:6], dec_cls.itype};

  alu_op_decoder u_dec (
    .opcode   (instr[31:26]),
    .funct    (instr[5:0]),
    .alu_code (dec_alu),
    .imm_sext (dec_sext),
    .a_sel    (dec_a_sel),
    .b_sel    (dec_b_sel),
    .cls      (dec_cls)
  );

  assign accept = instr_valid && instr_ready;

  // Decode happens on the accept edge, so controls are already registered
  // and stable for the whole DECODE cycle and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q      <= '0;
      a_sel_q    <= 1'b0;
      b_sel_q    <= 1'b0;
      sext_q     <= 1'b0;
      reg_dst_q  <= 1'b0;
      dst_zero_q <= 1'b0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      branch_q   <= 1'b0;
      jump_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (accept) begin
      alu_q      <= ALU_CTRL_W'(dec_alu);
      a_sel_q    <= dec_a_sel;
      b_sel_q    <= dec_b_sel;
      sext_q     <= dec_sext;
      reg_dst_q  <= dec_cls.rtype;
      dst_zero_q <= dec_cls.rtype ? (instr[15:11] == 5'd0) : (instr[20:16] == 5'd0);
      load_q     <= dec_cls.load;
      store_q    <= dec_cls.store;
      branch_q   <= dec_cls.branch;
      jump_q     <= dec_cls.jump;
      illegal_q  <= dec_cls.illegal;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:    if (accept) state_nxt = DECODE;
      DECODE:   if (illegal_q)      state_nxt = TRAP;
                else if (jump_q)    state_nxt = FETCH;
                else                state_nxt = EXEC;
      EXEC:     state_nxt = ALU_WAIT;
      ALU_WAIT: if (branch_q)                state_nxt = FETCH;
                else if (load_q || store_q)  state_nxt = MEM;
                else                         state_nxt = WB;
      MEM:      state_nxt = load_q ? WB : FETCH;
      WB:       state_nxt = FETCH;
      TRAP:     state_nxt = TRAP;
      default:  state_nxt = FETCH;
    endcase
  end

  assign alu_ctrl  = alu_q;
  assign alu_a_sel = a_sel_q;
  assign alu_b_sel = b_sel_q;
  assign imm_sext  = sext_q;
  assign reg_dst   = reg_dst_q;

  // Per-state strobes; instr_ready is gated by rst_n so it stays low in reset
  always_comb begin
    instr_ready = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_SEQ;
    illegal     = 1'b0;
    case (state)
      FETCH:  instr_ready = rst_n;
      DECODE: if (jump_q) begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
      end
      ALU_WAIT: if (branch_q) begin
        pc_write = 1'b1;
        pc_src   = alu_pcsinal ? PC_SRC_BRANCH : PC_SRC_SEQ;
      end
      MEM: begin
        mem_read = load_q;
        if (store_q) begin
          mem_write = 1'b1;
          pc_write  = 1'b1;
        end
      end
      WB: begin
        reg_write  = !dst_zero_q;
        mem_to_reg = load_q;
        pc_write   = 1'b1;
      end
      TRAP:    illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Directed self-checking bench for alu_ctrl_fsm.
module tb_alu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        alu_pcsinal = 1'b0;
  logic [4:0]  alu_ctrl;
  logic        alu_a_sel, alu_b_sel, imm_sext;
  logic        reg_write, reg_dst, mem_to_reg, mem_read, mem_write, pc_write;
  logic [1:0]  pc_src;
  logic        illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_ctrl_fsm #(.ALU_CTRL_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_pcsinal (alu_pcsinal),
    .alu_ctrl    (alu_ctrl),
    .alu_a_sel   (alu_a_sel),
    .alu_b_sel   (alu_b_sel),
    .imm_sext    (imm_sext),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .illegal     (illegal)
  );

  // {reg_write, mem_read, mem_write, pc_write, pc_src}
  wire [5:0] strobes = {reg_write, mem_read, mem_write, pc_write, pc_src};
  // {alu_a_sel, alu_b_sel, imm_sext, reg_dst}
  wire [3:0] sels    = {alu_a_sel, alu_b_sel, imm_sext, reg_dst};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word in FETCH, step into DECODE and scramble the bus afterwards
  task automatic issue(input string tag, input logic [31:0] w);
    instr = w;
    instr_valid = 1'b1;
    chk({tag, ".ready"}, instr_ready, 1'b1);
    step();
    instr_valid = 1'b0;
    instr = 32'hDEAD_BEEF;
  endtask

  // ALU-to-register instruction: 5 cycles accept..pc_write inclusive
  task automatic run_alu(input string tag, input logic [31:0] w, input logic [4:0] code,
                         input logic [3:0] sel, input logic rw);
    issue(tag, w);
    chk({tag, ".alu"}, alu_ctrl, code);
    chk({tag, ".sel"}, sels, sel);
    chk({tag, ".dec_strb"}, strobes, 6'b000000);
    step();
    chk({tag, ".exec_strb"}, strobes, 6'b000000);
    step();
    chk({tag, ".wait_strb"}, strobes, 6'b000000);
    step();
    chk({tag, ".wb_strb"}, strobes, {rw, 5'b00100});
    chk({tag, ".wb_m2r"}, mem_to_reg, 1'b0);
    chk({tag, ".wb_alu_hold"}, alu_ctrl, code);
    step();
    chk({tag, ".next_ready"}, instr_ready, 1'b1);
    chk({tag, ".next_strb"}, strobes, 6'b000000);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst.ready", instr_ready, 1'b0);
    chk("rst.strb", strobes, 6'b000000);
    chk("rst.alu", alu_ctrl, 5'b00000);
    chk("rst.sel", sels, 4'b0000);
    chk("rst.misc", {mem_to_reg, illegal}, 2'b00);
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rel.ready", instr_ready, 1'b1);
    step();

    // R-type and I-type ALU ops
    run_alu("add", 32'h0022_1820, 5'b00000, 4'b0001, 1'b1);
    run_alu("sll", 32'h0003_1100, 5'b01000, 4'b1001, 1'b1);
    run_alu("nop", 32'h0000_0000, 5'b01000, 4'b1001, 1'b0);
    run_alu("lui", 32'h3C01_1234, 5'b01100, 4'b0100, 1'b1);
    run_alu("slti", 32'h2841_FFFF, 5'b00110, 4'b0110, 1'b1);
    run_alu("andi", 32'h3041_0F0F, 5'b00010, 4'b0100, 1'b1);
    run_alu("sub", 32'h0022_1822, 5'b00001, 4'b0001, 1'b1);

    // beq taken
    issue("beqT", 32'h1022_0004);
    chk("beqT.alu", alu_ctrl, 5'b00010);
    chk("beqT.sel", sels, 4'b0000);
    step();
    alu_pcsinal = 1'b1;
    chk("beqT.exec_strb", strobes, 6'b000000);
    step();
    chk("beqT.wait_strb", strobes, 6'b000101);
    step();
    alu_pcsinal = 1'b0;
    chk("beqT.next_ready", instr_ready, 1'b1);
    chk("beqT.next_strb", strobes, 6'b000000);

    // beq not taken
    issue("beqN", 32'h1022_0004);
    step();
    step();
    chk("beqN.wait_strb", strobes, 6'b000100);
    step();
    chk("beqN.next_ready", instr_ready, 1'b1);

    // bne taken
    issue("bne", 32'h1422_0004);
    chk("bne.alu", alu_ctrl, 5'b01011);
    step();
    alu_pcsinal = 1'b1;
    step();
    chk("bne.wait_strb", strobes, 6'b000101);
    step();
    alu_pcsinal = 1'b0;
    chk("bne.next_ready", instr_ready, 1'b1);

    // lw: 6 cycles
    issue("lw", 32'h8C43_0008);
    chk("lw.alu", alu_ctrl, 5'b00000);
    chk("lw.sel", sels, 4'b0110);
    step();
    step();
    chk("lw.wait_strb", strobes, 6'b000000);
    step();
    chk("lw.mem_strb", strobes, 6'b010000);
    step();
    chk("lw.wb_strb", strobes, 6'b100100);
    chk("lw.wb_m2r", mem_to_reg, 1'b1);
    chk("lw.wb_dst", reg_dst, 1'b0);
    step();
    chk("lw.next_ready", instr_ready, 1'b1);

    // sw: 5 cycles
    issue("sw", 32'hAC43_0008);
    chk("sw.sel", sels, 4'b0110);
    step();
    step();
    step();
    chk("sw.mem_strb", strobes, 6'b001100);
    step();
    chk("sw.next_ready", instr_ready, 1'b1);
    chk("sw.next_strb", strobes, 6'b000000);

    // j: 2 cycles
    issue("j", 32'h0800_0010);
    chk("j.dec_strb", strobes, 6'b000110);
    step();
    chk("j.next_ready", instr_ready, 1'b1);
    chk("j.next_strb", strobes, 6'b000000);

    // Reset while in EXEC abandons the instruction
    issue("rstx", 32'h0022_1820);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstx.strb", strobes, 6'b000000);
    chk("rstx.ready", instr_ready, 1'b0);
    chk("rstx.sel", sels, 4'b0000);
    step();
    chk("rstx.hold_strb", strobes, 6'b000000);
    rst_n = 1'b1;
    #1;
    chk("rstx.rel_ready", instr_ready, 1'b1);
    step();
    step();
    chk("rstx.idle_strb", strobes, 6'b000000);
    chk("rstx.idle_ready", instr_ready, 1'b1);

    // Illegal opcode traps until reset
    issue("ill", 32'hFC00_0000);
    chk("ill.dec_flag", illegal, 1'b0);
    step();
    chk("ill.flag", illegal, 1'b1);
    chk("ill.ready", instr_ready, 1'b0);
    instr = 32'h0022_1820;
    instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ill.sticky", {illegal, instr_ready, pc_write, reg_write}, 4'b1000);
    end
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("ill.rst_clear", illegal, 1'b0);
    step();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multi-cycle MIPS32 control sequencer that drives the ALU: the producer of the 5-bit ALU control code and the consumer of the ALU's branch/compare flag (pcsinal).
- Accepts one instruction word per handshake, decodes it, issues the ALU code and operand selects, and waits out the ALU's one-cycle registered latency.
- Resolves beq/bne from the flag and sequences memory access, register write-back and PC update.

Parameters:
ALU_CTRL_W, 5, width of alu_ctrl; matches the ALU control port.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
instr  in  32  instruction word from fetch.
instr_valid  in  1  instr is valid.
instr_ready  out  1  controller is in FETCH; the word is accepted when valid&&ready.
alu_pcsinal  in  1  ALU flag, registered by the ALU, sampled in ALU_WAIT only.
alu_ctrl  out  5  ALU op code.
alu_a_sel  out  1  0=rs data, 1=zero-extended shamt.
alu_b_sel  out  1  0=rt data, 1=extended imm16.
imm_sext  out  1  1=sign-extend imm16, 0=zero-extend.
reg_write  out  1  write-back strobe, 1 cycle.
reg_dst  out  1  0=rt, 1=rd.
mem_to_reg  out  1  write-back data from memory.
mem_read  out  1  load strobe, 1 cycle.
mem_write  out  1  store strobe, 1 cycle.
pc_write  out  1  PC update strobe, exactly one per retired instruction.
pc_src  out  2  00=PC+4, 01=branch target, 10=jump target.
illegal  out  1  sticky unsupported-instruction flag.

Behaviour:
- Reset (async, rst_n low):
  - State goes to FETCH immediately.
  - All outputs except instr_ready go to 0; alu_ctrl=00000 (add).
  - instr_ready is 0 while rst_n is low, then 1 from the first cycle rst_n is high.
  - Reset mid-instruction abandons it: no pc_write, no reg_write.
- ALU codes: add 00000, sub 00001, and 00010, or 00011, xor 00100, nor 00101, slt 00110, sll 01000, srl 01001, sra 01010, bne 01011, lui 01100.
- Flag semantics:
  - The and code doubles as the beq comparator: flag=1 when operands are equal.
  - The bne code gives flag=1 when operands are not equal.
- Supported R-type funct: add/addu 20/21→add; sub/subu 22/23→sub; 24 and; 25 or; 26 xor; 27 nor; 2A slt; 00 sll, 02 srl, 03 sra (alu_a_sel=1).
- Supported I-type opcodes:
  - addi/addiu 08/09→add, slti 0A→slt: sign-extended.
  - andi 0C, ori 0D, xori 0E: zero-extended.
  - lui 0F→lui, zero-extended (the ALU shifts B left by 16).
  - lw 23 / sw 2B→add, sign-extended.
  - beq 04→and, bne 05→bne, both alu_b_sel=0.
  - j 02.
- State sequence:
  - FETCH: instr_ready=1. On valid&&ready, latch instr and go to DECODE.
  - DECODE: register all control outputs.
    - Unsupported instruction → TRAP.
    - j → pc_write=1, pc_src=10, back to FETCH.
    - Otherwise → EXEC.
  - EXEC: alu_ctrl and selects stable; the ALU registers its result at the end of this cycle. → ALU_WAIT.
  - ALU_WAIT:
    - Branch: pc_write=1; pc_src=01 if alu_pcsinal else 00; → FETCH.
    - lw/sw: → MEM.
    - Otherwise: → WB.
  - MEM:
    - lw: mem_read=1, → WB.
    - sw: mem_write=1, pc_write=1, pc_src=00, → FETCH.
  - WB: reg_write=1 (mem_to_reg=1 for lw), pc_write=1, pc_src=00, → FETCH.
    - reg_write is suppressed when the destination register is 0 (nop = sll $0); pc_write still fires.
  - TRAP: illegal=1, instr_ready=0; held until reset.
- Latency, counted from the accept cycle to the pc_write cycle inclusive: j 2, beq/bne 4, R/I-type ALU 5, sw 5, lw 6.
- Outputs are stable through each state. alu_ctrl is held from DECODE until the next DECODE.
- instr_valid is ignored outside FETCH. instr must not be sampled except on accept.

Decomposition:
- Package mips_ctrl_pkg:
  - opcode and funct constants;
  - ALU code constants (5-bit);
  - state enum {FETCH, DECODE, EXEC, ALU_WAIT, MEM, WB, TRAP};
  - pc_src encodings.
- One combinational sub-module, alu_op_decoder: opcode/funct → alu code, imm_sext, operand selects, instruction class (rtype, itype, load, store, branch, jump, illegal).
- The FSM and output registers stay in alu_ctrl_fsm.

Test Plan:
- add $3,$1,$2 (0x00221820):
  - alu_ctrl=00000, a_sel=0, b_sel=0.
  - 4 cycles after accept: reg_write=1, reg_dst=1, pc_write=1, pc_src=00.
  - instr_ready=1 the next cycle.
- beq (0x10220004):
  - alu_ctrl=00010.
  - pcsinal=1 in ALU_WAIT → pc_write, pc_src=01.
  - Repeat with pcsinal=0 → pc_src=00, no reg_write.
- bne (0x14220004): alu_ctrl=01011; pcsinal=1 → pc_src=01, 3 cycles after accept.
- lw $3,8($2) (0x8C430008):
  - alu_ctrl=00000, b_sel=1, imm_sext=1.
  - mem_read pulse in MEM.
  - Next cycle: reg_write, mem_to_reg, reg_dst=0, pc_write.
- Operand-select opcodes:
  - sll $2,$3,4 (0x00031100): alu_ctrl=01000, a_sel=1.
  - lui $1,0x1234 (0x3C011234): alu_ctrl=01100, imm_sext=0.
  - j (0x08000010): pc_src=10 one cycle after accept.
- Illegal instruction and reset:
  - Opcode 0x3F (0xFC000000) → illegal=1 sticky, instr_ready=0 despite instr_valid.
  - Assert rst_n=0 while in EXEC → outputs clear immediately, no pc_write; FETCH after release.
